// File: rtl/sort_4.sv
// Pipelined 4-input unsigned sorter: a registered 5-comparator network in three
// compare-exchange stages, with a valid bit that travels alongside each stage.
module sort_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [WIDTH-1:0] ra,
  output logic [WIDTH-1:0] rb,
  output logic [WIDTH-1:0] rc,
  output logic [WIDTH-1:0] rd
);

  function automatic logic [WIDTH-1:0] cx_lo(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x < y) ? x : y;
  endfunction

  function automatic logic [WIDTH-1:0] cx_hi(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x < y) ? y : x;
  endfunction

  logic             vld_p1, vld_p2;
  logic [WIDTH-1:0] l1_p1, h1_p1, l2_p1, h2_p1;
  logic [WIDTH-1:0] mn_p2, m1_p2, m2_p2, mx_p2;

  // Stage 1: order each input pair
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      l1_p1  <= '0;
      h1_p1  <= '0;
      l2_p1  <= '0;
      h2_p1  <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        l1_p1 <= cx_lo(a, b);
        h1_p1 <= cx_hi(a, b);
        l2_p1 <= cx_lo(c, d);
        h2_p1 <= cx_hi(c, d);
      end
    end
  end

  // Stage 2: global min/max settle; the two middle candidates remain unordered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      mn_p2  <= '0;
      m1_p2  <= '0;
      m2_p2  <= '0;
      mx_p2  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mn_p2 <= cx_lo(l1_p1, l2_p1);
        m1_p2 <= cx_hi(l1_p1, l2_p1);
        m2_p2 <= cx_lo(h1_p1, h2_p1);
        mx_p2 <= cx_hi(h1_p1, h2_p1);
      end
    end
  end

  // Stage 3: order the middle pair straight into the output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      rd        <= '0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        ra <= mn_p2;
        rb <= cx_lo(m1_p2, m2_p2);
        rc <= cx_hi(m1_p2, m2_p2);
        rd <= mx_p2;
      end
    end
  end

endmodule

// File: tb/tb_sort_4.sv
// Bench for sort_4: directed and random sets compared each cycle against a
// reference model that sorts each accepted set and releases it three cycles later.
module tb_sort_4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a, b, c, d;
  logic             out_valid;
  logic [WIDTH-1:0] ra, rb, rc, rd;

  int n_asserts = 0;
  int n_fails   = 0;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] s0, s1, s2, s3;
  } ent_t;

  ent_t q[$];
  logic             exp_ov;
  logic [WIDTH-1:0] exp_r0, exp_r1, exp_r2, exp_r3;

  sort_4 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid),
    .ra(ra), .rb(rb), .rc(rc), .rd(rd)
  );

  always #5 clk = ~clk;

  function automatic ent_t ref_sort(input bit v, input int x0, input int x1, input int x2, input int x3);
    int arr[4];
    int t;
    ent_t e;
    arr[0] = x0; arr[1] = x1; arr[2] = x2; arr[3] = x3;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (arr[j] > arr[j+1]) begin
          t = arr[j]; arr[j] = arr[j+1]; arr[j+1] = t;
        end
    e.v  = v;
    e.s0 = WIDTH'(arr[0]);
    e.s1 = WIDTH'(arr[1]);
    e.s2 = WIDTH'(arr[2]);
    e.s3 = WIDTH'(arr[3]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle, let the edge happen, then update the model and compare.
  task automatic step(input bit r, input bit v, input int x0, input int x1, input int x2, input int x3);
    ent_t e;
    rst_n = r; in_valid = v;
    a = WIDTH'(x0); b = WIDTH'(x1); c = WIDTH'(x2); d = WIDTH'(x3);
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete();
      exp_ov = 1'b0;
      exp_r0 = '0; exp_r1 = '0; exp_r2 = '0; exp_r3 = '0;
    end else begin
      q.push_back(ref_sort(v, x0, x1, x2, x3));
      exp_ov = 1'b0;
      if (q.size() == 3) begin
        e = q.pop_front();
        exp_ov = e.v;
        if (e.v) begin
          exp_r0 = e.s0; exp_r1 = e.s1; exp_r2 = e.s2; exp_r3 = e.s3;
        end
      end
    end
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("ra", 32'(ra), 32'(exp_r0));
    chk("rb", 32'(rb), 32'(exp_r1));
    chk("rc", 32'(rc), 32'(exp_r2));
    chk("rd", 32'(rd), 32'(exp_r3));
    if (exp_ov) begin
      n_asserts++;
      assert (ra <= rb && rb <= rc && rc <= rd) else begin
        n_fails++;
        $error("FAIL order: observed %0d,%0d,%0d,%0d expected ascending", ra, rb, rc, rd);
      end
    end
  endtask

  task automatic rnd_step(input bit r, input bit v);
    step(r, v, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
         int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
  endtask

  initial begin
    exp_ov = 1'b0;
    exp_r0 = '0; exp_r1 = '0; exp_r2 = '0; exp_r3 = '0;

    // Reset with in_valid high and random data, then idle after release
    rnd_step(1'b0, 1'b1);
    rnd_step(1'b0, 1'b1);
    repeat (3) rnd_step(1'b1, 1'b0);

    // Single set, then idle so the result is seen held with out_valid low
    step(1'b1, 1'b1, 9, 3, 14, 0);
    repeat (4) rnd_step(1'b1, 1'b0);
    chk("single_ra", 32'(ra), 32'd0);
    chk("single_rb", 32'(rb), 32'd3);
    chk("single_rc", 32'(rc), 32'd9);
    chk("single_rd", 32'(rd), 32'd14);

    // Ties and extremes
    step(1'b1, 1'b1, 5, 5, 5, 5);
    step(1'b1, 1'b1, 15, 0, 15, 0);
    step(1'b1, 1'b1, 7, 7, 2, 7);
    step(1'b1, 1'b1, 0, 0, 0, 0);
    step(1'b1, 1'b1, 15, 15, 15, 15);
    repeat (3) rnd_step(1'b1, 1'b0);

    // Streaming: 50 back-to-back random sets
    for (int i = 0; i < 50; i++)
      step(1'b1, 1'b1, int'($urandom_range(14, 0)), int'($urandom_range(14, 0)),
           int'($urandom_range(14, 0)), int'($urandom_range(14, 0)));
    repeat (3) rnd_step(1'b1, 1'b0);

    // Bubbles: valid pattern 1,0,1,1,0
    step(1'b1, 1'b1, 1, 2, 3, 4);
    rnd_step(1'b1, 1'b0);
    step(1'b1, 1'b1, 4, 3, 2, 1);
    step(1'b1, 1'b1, 8, 1, 8, 1);
    rnd_step(1'b1, 1'b0);
    repeat (3) rnd_step(1'b1, 1'b0);

    // Reset mid-stream with three sets in flight
    step(1'b1, 1'b1, 11, 2, 7, 4);
    step(1'b1, 1'b1, 13, 13, 1, 6);
    step(1'b1, 1'b1, 3, 9, 9, 0);
    rnd_step(1'b0, 1'b1);
    chk("rst_mid_ov", 32'(out_valid), 32'd0);
    chk("rst_mid_rd", 32'(rd), 32'd0);
    step(1'b1, 1'b1, 12, 6, 3, 10);
    rnd_step(1'b1, 1'b0);
    rnd_step(1'b1, 1'b0);
    chk("post_rst_ov", 32'(out_valid), 32'd1);
    chk("post_rst_ra", 32'(ra), 32'd3);
    chk("post_rst_rb", 32'(rb), 32'd6);
    chk("post_rst_rc", 32'(rc), 32'd10);
    chk("post_rst_rd", 32'(rd), 32'd12);
    repeat (2) rnd_step(1'b1, 1'b0);

    // Random mix of valid, bubbles and occasional reset
    for (int i = 0; i < 200; i++)
      rnd_step(($urandom_range(19, 0) != 0), ($urandom_range(3, 0) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
